cmd_sender: RTL and testbench

- Transmit-side counterpart of the robot's command receive path. It sits at the remote/host end of the serial link.
- Accepts a 16-bit command word and serialises it on TX as two 8N1 UART frames: high byte first, then low byte.
- This byte order matches the receiver's 2-byte command assembly.
- Signals completion with a cmd_snt flag that stays set until the next send, the same handshake style the command receive path uses.

---
 rtl/cmd_tx_pkg.sv | 21 ++
 rtl/cmd_sender_if.sv | 11 +
 rtl/UART_tx.sv | 72 +++++++
 rtl/cmd_sender.sv | 122 ++++++++++++
 tb/tb_cmd_sender.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_tx_pkg.sv
// Shared types and constants for the command transmit path.
package cmd_tx_pkg;

  // GAP keeps its encoding even when the inter-frame gap is compiled out
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2,
    LOW  = 2'd3
  } state_e;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Bits needed to hold div-1 (the baud counter reload value)
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/cmd_sender_if.sv
// Host-side command handshake plus the serial line.
interface cmd_sender_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        TX;
  logic        tx_busy;
  logic        cmd_snt;

  modport master (output snd_cmd, cmd, input TX, tx_busy, cmd_snt);
  modport slave  (input snd_cmd, cmd, output TX, tx_busy, cmd_snt);
endinterface

// File: rtl/UART_tx.sv
// Single-byte 8N1 transmitter. A trmt pulse loads a frame; tx_done pulses on
// the last clock of the stop bit, so a new trmt on that same clock chains the
// next frame with no idle gap.
module UART_tx
  import cmd_tx_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int            CW       = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  logic                  busy_q, busy_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  bit_end;

  assign bit_end = busy_q && (baud_q == '0);
  assign tx_done = bit_end && (bit_q == LAST_BIT);
  // Line is the shift register's LSB, so TX comes straight from a flop
  assign TX      = shift_q[0];

  // Load / count-down / shift-out sequencing
  always_comb begin
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (trmt) begin
      busy_d  = 1'b1;
      baud_d  = BAUD_MAX;
      bit_d   = 4'd0;
      shift_d = {STOP_BIT, tx_data, START_BIT};
    end else if (bit_end) begin
      baud_d  = BAUD_MAX;
      shift_d = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
      if (bit_q == LAST_BIT) begin
        busy_d = 1'b0;
        bit_d  = 4'd0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else if (busy_q) begin
      baud_d = baud_q - 1'b1;
    end
  end

  // State registers; reset abandons any frame and idles the line high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= '1;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/cmd_sender.sv
// Sends a 16-bit command as two 8N1 frames, high byte first.
// Optional macro CMD_TX_GAP_EN inserts one idle bit time between the frames.
module cmd_sender
  import cmd_tx_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic         clk,
  input  logic         rst,
  cmd_sender_if.slave  bus
);

`ifdef CMD_TX_GAP_EN
  localparam int            CW       = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
  logic [CW-1:0] gap_q, gap_d;
`endif

  state_e      state_q, state_d;
  logic [15:0] cmd_hold_q, cmd_hold_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic        tx_busy_q, tx_busy_d;
  logic        launch_q, launch_d;
  logic        chain;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  // launch_q starts the high frame one cycle after acceptance; chain starts
  // the low frame exactly when the previous frame (or gap) ends
  assign trmt        = launch_q | chain;
  assign tx_data     = launch_q ? cmd_hold_q[15:8] : cmd_hold_q[7:0];
  assign bus.tx_busy = tx_busy_q;
  assign bus.cmd_snt = cmd_snt_q;

  UART_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (bus.TX),
    .tx_done (tx_done)
  );

  // Byte-sequencing FSM: next state, flags and frame launch
  always_comb begin
    state_d    = state_q;
    cmd_hold_d = cmd_hold_q;
    cmd_snt_d  = cmd_snt_q;
    tx_busy_d  = tx_busy_q;
    launch_d   = 1'b0;
    chain      = 1'b0;
`ifdef CMD_TX_GAP_EN
    gap_d      = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.snd_cmd) begin
          cmd_hold_d = bus.cmd;
          cmd_snt_d  = 1'b0;
          tx_busy_d  = 1'b1;
          launch_d   = 1'b1;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (tx_done) begin
`ifdef CMD_TX_GAP_EN
          state_d = GAP;
          gap_d   = BAUD_MAX;
`else
          state_d = LOW;
          chain   = 1'b1;
`endif
        end
      end
`ifdef CMD_TX_GAP_EN
      GAP: begin
        // Transmitter is idle here, so the line sits high for BAUD_DIV clocks
        if (gap_q == '0) begin
          state_d = LOW;
          chain   = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
`endif
      LOW: begin
        if (tx_done) begin
          cmd_snt_d = 1'b1;
          tx_busy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_hold_q <= '0;
      cmd_snt_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      launch_q   <= 1'b0;
`ifdef CMD_TX_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_hold_q <= cmd_hold_d;
      cmd_snt_q  <= cmd_snt_d;
      tx_busy_q  <= tx_busy_d;
      launch_q   <= launch_d;
`ifdef CMD_TX_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_sender.sv
// Bench for cmd_sender: directed sends, a UART-decoding monitor that pops
// expected command words from a scoreboard queue, and cycle-exact checks.
module tb_cmd_sender;

  localparam int B = 16;
`ifdef CMD_TX_GAP_EN
  localparam int GAPC = B;
`else
  localparam int GAPC = 0;
`endif
  localparam int LAT     = 20*B + 1 + GAPC;
  localparam int SPACING = 10*B + GAPC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cmd_sender_if bus();

  cmd_sender #(.BAUD_DIV(B)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor: decode TX, compare against scoreboard ----------
  int rx_on = 0, rx_start = 0, have_hi = 0, hi_start = 0, mk = 0, mj = 0;
  logic [7:0] rx_byte = 8'h00, hi_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_on   = 0;
      have_hi = 0;
    end else if (rx_on == 0) begin
      if (bus.TX == 1'b0) begin
        rx_on    = 1;
        rx_start = cyc;
      end
    end else begin
      mk = cyc - rx_start;
      if ((mk % B) == B/2) begin
        mj = mk / B;
        if (mj == 0) chk("start_bit", 32'(bus.TX), 32'd0);
        else if (mj <= 8) rx_byte[mj-1] = bus.TX;
        else begin
          chk("stop_bit", 32'(bus.TX), 32'd1);
          rx_on = 0;
          if (have_hi == 0) begin
            hi_byte  = rx_byte;
            hi_start = rx_start;
            have_hi  = 1;
          end else begin
            have_hi = 0;
            chk("frame_spacing", 32'(rx_start - hi_start), 32'(SPACING));
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_word: got %0h expected none", {hi_byte, rx_byte});
            end else begin
              chk("rx_word", 32'({hi_byte, rx_byte}), 32'(exp_q.pop_front()));
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic accept(input logic [15:0] c);
    @(negedge clk);
    bus.cmd     = c;
    bus.snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    t0          = cyc;
    bus.snd_cmd = 1'b0;
  endtask

  // Advance to the falling edge where cyc - t0 == n
  task automatic wait_rel(input int n);
    do @(negedge clk); while (cyc - t0 < n);
  endtask

  task automatic run_send(input logic [15:0] c, input logic [19:0] pat, input bit chk_pat);
    exp_q.push_back(c);
    accept(c);
    wait_rel(0);
    chk("tx_idle_c0", 32'(bus.TX), 32'd1);
    chk("busy_c0", 32'(bus.tx_busy), 32'd1);
    chk("snt_clear_c0", 32'(bus.cmd_snt), 32'd0);
    wait_rel(1);
    chk("tx_start_c1", 32'(bus.TX), 32'd0);
    if (chk_pat) begin
      for (int i = 0; i < 20; i++) begin
        wait_rel(1 + i*B + B/2 + ((i >= 10) ? GAPC : 0));
        chk("tx_bit", 32'(bus.TX), 32'(pat[i]));
      end
    end
    wait_rel(LAT - 1);
    chk("busy_before_done", 32'(bus.tx_busy), 32'd1);
    chk("snt_before_done", 32'(bus.cmd_snt), 32'd0);
    wait_rel(LAT);
    chk("snt_at_done", 32'(bus.cmd_snt), 32'd1);
    chk("busy_at_done", 32'(bus.tx_busy), 32'd0);
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    logic [19:0] pat;
    logic        bad;
    bus.snd_cmd = 1'b0;
    bus.cmd     = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(bus.TX), 32'd1);
    chk("reset_busy", 32'(bus.tx_busy), 32'd0);
    chk("reset_snt", 32'(bus.cmd_snt), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // A5C3: line bits in time order, high frame in pat[9:0]
    pat = {10'b1110000110, 10'b1101001010};
    run_send(16'hA5C3, pat, 1'b1);

    // Idle with cmd_snt held
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.cmd_snt !== 1'b1 || bus.TX !== 1'b1) bad = 1'b1;
    end
    chk("idle_hold", 32'(bad), 32'd0);
    run_send(16'h5A3C, pat, 1'b0);

    // snd_cmd held high; cmd changes while busy
    exp_q.push_back(16'hA5C3);
    exp_q.push_back(16'h1234);
    @(negedge clk);
    bus.cmd     = 16'hA5C3;
    bus.snd_cmd = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    wait_rel(5);
    bus.cmd = 16'h1234;
    wait_rel(LAT);
    chk("hold_snt_first", 32'(bus.cmd_snt), 32'd1);
    chk("hold_busy_gap", 32'(bus.tx_busy), 32'd0);
    wait_rel(LAT + 1);
    chk("hold_busy_second", 32'(bus.tx_busy), 32'd1);
    chk("hold_snt_cleared", 32'(bus.cmd_snt), 32'd0);
    chk("hold_tx_idle", 32'(bus.TX), 32'd1);
    wait_rel(LAT + 2);
    chk("hold_tx_start", 32'(bus.TX), 32'd0);
    wait_rel(400);
    bus.snd_cmd = 1'b0;
    wait_rel(2*LAT + 1);
    chk("hold_snt_second", 32'(bus.cmd_snt), 32'd1);
    wait_rel(2*LAT + 20);
    chk("hold_no_third", 32'(bus.tx_busy), 32'd0);

    // Reset in the middle of the high byte
    accept(16'hBEEF);
    wait_rel(99);
    chk("pre_reset_busy", 32'(bus.tx_busy), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(bus.TX), 32'd1);
    chk("async_rst_busy", 32'(bus.tx_busy), 32'd0);
    chk("async_rst_snt", 32'(bus.cmd_snt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_send(16'h00FF, pat, 1'b0);

`ifdef CMD_TX_GAP_EN
    // Idle bit time between frames
    exp_q.push_back(16'hFF00);
    accept(16'hFF00);
    wait_rel(10*B);
    chk("gap_stop_bit", 32'(bus.TX), 32'd1);
    bad = 1'b0;
    for (int r = 10*B + 1; r <= 11*B; r++) begin
      wait_rel(r);
      if (bus.TX !== 1'b1) bad = 1'b1;
    end
    chk("gap_idle", 32'(bad), 32'd0);
    wait_rel(11*B + 1);
    chk("gap_low_start", 32'(bus.TX), 32'd0);
    wait_rel(LAT - 1);
    chk("gap_snt_before", 32'(bus.cmd_snt), 32'd0);
    wait_rel(LAT);
    chk("gap_snt_at_337", 32'(bus.cmd_snt), 32'd1);
`endif

    repeat (12*B) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
